// File: rtl/aes_xram_responder.sv
// rtl/aes_xram_responder.sv - byte-wide XRAM responder with programmable ack latency (optional XRAM_BACKDOOR_EN preload port)
module aes_xram_responder #(
    parameter int ADDR_W  = 16,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] xram_addr,
    input  logic [7:0]        xram_data_out,
    input  logic              xram_stb,
    input  logic              xram_wr,
    output logic              xram_ack,
    output logic [7:0]        xram_data_in,
    output logic              busy,
    output logic              err
`ifdef XRAM_BACKDOOR_EN
    ,
    input  logic              bd_we,
    input  logic [ADDR_W-1:0] bd_addr,
    input  logic [7:0]        bd_data
`endif
);

    localparam int MEM_AW = $clog2(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    generate
        if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
            $error("aes_xram_responder: LATENCY must be within 1..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    logic              armed;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] req_addr;
    logic [7:0]        req_data;
    logic              req_wr;
    logic              capture;
    logic              commit;
    logic              req_in_range;
    logic [7:0]        mem [DEPTH];

    // A request is accepted only from IDLE once stb has been seen low since the last ack.
    // WAIT always spans LATENCY cycles so ack lands in the cycle after edge E0+LATENCY for every legal LATENCY.
    assign capture      = (state == S_IDLE) && xram_stb && armed;
    assign commit       = (state == S_WAIT) && (cnt == 4'd0) && !rst;
    assign req_in_range = ({1'b0, req_addr} < DEPTH_LIM);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (capture) state_nx = S_WAIT;
            S_WAIT:  if (cnt == 4'd0) state_nx = S_ACK;
            S_ACK:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        xram_ack = (state == S_ACK);
        busy     = (state != S_IDLE);
    end

    // Request capture, latency counter, arming, read data and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            armed        <= 1'b1;
            cnt          <= 4'd0;
            req_addr     <= '0;
            req_data     <= 8'h00;
            req_wr       <= 1'b0;
            xram_data_in <= 8'h00;
            err          <= 1'b0;
        end else begin
            // A low stb re-arms even in the ack cycle; otherwise the ack disarms.
            if (!xram_stb) begin
                armed <= 1'b1;
            end else if (state == S_ACK) begin
                armed <= 1'b0;
            end
            if (capture) begin
                req_addr <= xram_addr;
                req_data <= xram_data_out;
                req_wr   <= xram_wr;
                cnt      <= CNT_LOAD;
            end else if (state == S_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (commit && !req_wr) begin
                xram_data_in <= req_in_range ? mem[req_addr[MEM_AW-1:0]] : 8'hFF;
            end
            if (commit && !req_in_range) begin
                err <= 1'b1;
            end
        end
    end

    // Storage: not reset; front-door write is last so it wins over a same-edge backdoor write
    always_ff @(posedge clk) begin
`ifdef XRAM_BACKDOOR_EN
        if (bd_we && ({1'b0, bd_addr} < DEPTH_LIM)) begin
            mem[bd_addr[MEM_AW-1:0]] <= bd_data;
        end
`endif
        if (commit && req_wr && req_in_range) begin
            mem[req_addr[MEM_AW-1:0]] <= req_data;
        end
    end

endmodule
